// File: rtl/arith_pkg.sv
// ---------------------------------------------------------------------------
// arith_pkg : shared prefix-arithmetic types and the (G,P) combine operator
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package arith_pkg;

  typedef struct packed {
    logic g;
    logic p;
  } pg_t;

  localparam int unsigned DEF_WIDTH  = 32'd8;
  localparam int unsigned DEF_LEVELS = $clog2(DEF_WIDTH);

  // Number of Kogge-Stone levels needed to span a WIDTH-bit operand.
  function automatic int unsigned prefix_levels(input int unsigned width);
    return $clog2(width);
  endfunction

  // (G,P) o (G',P') = (G | P&G', P&P'); hi is the more significant group.
  function automatic pg_t pg_combine(input pg_t hi, input pg_t lo);
    pg_t r;
    r.g = hi.g | (hi.p & lo.g);
    r.p = hi.p & lo.p;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/prefix_black_cell.sv
// ---------------------------------------------------------------------------
// prefix_black_cell : combinational prefix operator cell, shared with the adder
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module prefix_black_cell
  import arith_pkg::*;
(
  input  pg_t hi_i,
  input  pg_t lo_i,
  output pg_t grp_o
);

  assign grp_o = pg_combine(hi_i, lo_i);

endmodule

`default_nettype wire

// File: rtl/prefix_sub_pipe.sv
// ---------------------------------------------------------------------------
// prefix_sub_pipe : 3-stage valid/ready Kogge-Stone subtractor, a - b - bin
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module prefix_sub_pipe
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_diff,
  output logic             out_bout,
  output logic             out_zero,
  output logic             out_ovf
);

  localparam int unsigned L = prefix_levels(WIDTH);

  // Stage registers
  logic             s1_v_q, s2_v_q, s3_v_q;
  logic [WIDTH-1:0] s1_g_q, s1_p_q;
  logic             s1_cin_q, s1_amsb_q, s1_bmsb_q;
  logic [WIDTH-1:0] s2_g_q, s2_p_q;
  logic             s2_cin_q, s2_amsb_q, s2_bmsb_q;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q, zero_q, ovf_q;

  logic             w_adv1, w_adv2, w_adv3;
  logic [WIDTH-1:0] w_g_d, w_p_d, w_grp_d, w_carry, diff_d;
  logic             bout_d, zero_d, ovf_d;

  assign w_adv3   = ~s3_v_q | out_ready;
  assign w_adv2   = ~s2_v_q | w_adv3;
  assign w_adv1   = ~s1_v_q | w_adv2;
  assign in_ready = w_adv1;

  // Subtraction as a + ~b + ~bin.
  assign w_g_d = in_a & ~in_b;
  assign w_p_d = in_a ^ ~in_b;

  // Prefix tree; cin is folded into bit 0 so the tree yields G[i:-1] directly.
  pg_t lvl [L+1][WIDTH];

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_leaf
      if (i == 0) begin : g_cin
        assign lvl[0][i] = '{g: s1_g_q[0] | (s1_p_q[0] & s1_cin_q), p: s1_p_q[0]};
      end else begin : g_plain
        assign lvl[0][i] = '{g: s1_g_q[i], p: s1_p_q[i]};
      end
    end

    for (genvar k = 1; k <= L; k++) begin : g_level
      localparam int unsigned D = 32'd1 << (k - 1);
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (i >= D) begin : g_black
          prefix_black_cell u_cell (
            .hi_i  (lvl[k-1][i]),
            .lo_i  (lvl[k-1][i-D]),
            .grp_o (lvl[k][i])
          );
        end else begin : g_pass
          assign lvl[k][i] = lvl[k-1][i];
        end
      end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_out
      assign w_grp_d[i] = lvl[L][i].g;
    end
  endgenerate

  // Final-level group propagates are not needed once cin is folded in.
  logic w_unused_p;
  always_comb begin
    w_unused_p = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      w_unused_p = w_unused_p ^ lvl[L][i].p;
    end
  end

  assign w_carry = {s2_g_q[WIDTH-2:0], s2_cin_q};
  assign diff_d  = s2_p_q ^ w_carry;
  assign bout_d  = ~s2_g_q[WIDTH-1];
  assign zero_d  = (diff_d == '0);
  assign ovf_d   = (s2_amsb_q ^ s2_bmsb_q) & (s2_amsb_q ^ diff_d[WIDTH-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q    <= 1'b0;
      s2_v_q    <= 1'b0;
      s3_v_q    <= 1'b0;
      s1_g_q    <= '0;
      s1_p_q    <= '0;
      s1_cin_q  <= 1'b0;
      s1_amsb_q <= 1'b0;
      s1_bmsb_q <= 1'b0;
      s2_g_q    <= '0;
      s2_p_q    <= '0;
      s2_cin_q  <= 1'b0;
      s2_amsb_q <= 1'b0;
      s2_bmsb_q <= 1'b0;
      diff_q    <= '0;
      bout_q    <= 1'b0;
      zero_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      if (w_adv1) s1_v_q <= in_valid;
      if (w_adv2) s2_v_q <= s1_v_q;
      if (w_adv3) s3_v_q <= s2_v_q;

      // Data moves only with a real beat, so idle inputs never leak in.
      if (in_valid && w_adv1) begin
        s1_g_q    <= w_g_d;
        s1_p_q    <= w_p_d;
        s1_cin_q  <= ~in_bin;
        s1_amsb_q <= in_a[WIDTH-1];
        s1_bmsb_q <= in_b[WIDTH-1];
      end
      if (s1_v_q && w_adv2) begin
        s2_g_q    <= w_grp_d;
        s2_p_q    <= s1_p_q;
        s2_cin_q  <= s1_cin_q;
        s2_amsb_q <= s1_amsb_q;
        s2_bmsb_q <= s1_bmsb_q;
      end
      if (s2_v_q && w_adv3) begin
        diff_q <= diff_d;
        bout_q <= bout_d;
        zero_q <= zero_d;
        ovf_q  <= ovf_d;
      end
    end
  end

  assign out_valid = s3_v_q;
  assign out_diff  = diff_q;
  assign out_bout  = bout_q;
  assign out_zero  = zero_q;
  assign out_ovf   = ovf_q;

endmodule

`default_nettype wire

// File: doc/prefix_sub_pipe.md
Name: prefix_sub_pipe

Overview:
- Pipelined, flow-controlled prefix (Kogge-Stone) subtractor, the inverse arithmetic direction of the team's combinational 8-bit prefix adder.
- Computes diff = a - b - bin through a valid/ready stream interface, and reports borrow, zero and signed-overflow flags.
- Sits in the datapath wherever a registered, back-pressurable subtract is needed.
- Also serves as the hardware reference result for adder-versus-subtractor cross-checks.

Parameters:
- WIDTH, 8, operand width. Legal values are 4, 8 and 16 (power of two). Prefix levels L = log2(WIDTH).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset; synchronous, active-high
- in_valid  input  1  operand beat offered
- in_ready  output  1  block can accept a beat this cycle
- in_a  input  WIDTH  minuend
- in_b  input  WIDTH  subtrahend
- in_bin  input  1  borrow in
- out_valid  output  1  result beat available
- out_ready  input  1  consumer accepts result this cycle
- out_diff  output  WIDTH  a - b - bin, modulo 2^WIDTH
- out_bout  output  1  borrow out (1 when the unsigned result is negative)
- out_zero  output  1  out_diff == 0
- out_ovf  output  1  two's-complement overflow

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: all stage valids = 0, so out_valid = 0 and in_ready = 1 in the cycle after rst is sampled high. Data registers clear to 0, so out_diff = 0 and all flags = 0.
- Arithmetic:
  - Computed as a + ~b + cin, where cin = ~bin.
  - Generate/propagate pairs per bit: g = a & ~b, p = a ^ ~b.
  - Prefix operator (G,P)∘(G',P') = (G | P&G', P&P').
  - out_bout = ~carry_out.
  - out_ovf = (a[MSB]^b[MSB]) & (a[MSB]^diff[MSB]).
- Pipeline: three register stages. Latency from an accepted input to out_valid is exactly 3 cycles when not stalled.
  - S1: registers g, p, cin and the operand MSBs.
  - S2: all L prefix levels. Registers group generates G[i:0] with cin folded in as bit -1.
  - S3: sum = p ^ {G[i-1:0], cin}, plus flags. Registers drive the outputs directly; no combinational output logic.
- Handshake:
  - Transfer occurs when valid & ready are both high.
  - Stage k advances when it is empty or stage k+1 advances. S3 advances when out_ready = 1.
  - in_ready = ~S1_valid | S1_advance. This combinational path from out_ready is permitted.
  - While out_valid = 1 and out_ready = 0, the out_* signals stay stable.
  - Capacity is 3 beats. With out_ready held low, in_ready falls after the third accept.
  - Pop and push in the same cycle at full capacity: throughput is 1 beat per cycle with no bubble.
- Data acceptance: in_a, in_b and in_bin are sampled only on an accepted beat. They are don't-care otherwise.
- Reset mid-operation: all in-flight beats are discarded; nothing is emitted for them after reset.
- Boundaries:
  - Wrap-around is modulo 2^WIDTH (0 - 1 = all ones with bout = 1).
  - bin = 1 with a == b gives all ones, bout = 1.
  - No X propagation from unaccepted inputs.

Decomposition:
- Shared package arith_pkg:
  - pg_t, a struct {g, p}.
  - Function pg_combine implementing the prefix operator.
  - Constant localparam computing L from WIDTH.
- One natural sub-module: prefix_black_cell (combinational ∘ operator).
  - Instantiated L·WIDTH times, minus pass-throughs.
  - Reusable by the existing prefix adder.

Test Plan:
1. Reset then single beat a=0x68, b=0x2B, bin=0 -> 3 cycles later out_valid=1, diff=0x3D, bout=0, zero=0, ovf=0.
2. a=0x2C, b=0x43, bin=0 -> diff=0xE9, bout=1, ovf=0. Also a=0x80, b=0x01 -> diff=0x7F, bout=0, ovf=1.
3. Boundaries: a=0x14, b=0x14, bin=0 -> diff=0x00, zero=1. a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1. a=0x0A, b=0x14, bin=1 -> diff=0xF5, bout=1.
4. Backpressure: out_ready=0, offer 5 beats back-to-back -> exactly 3 accepted, then in_ready=0 and out_* stay stable. Raising out_ready drains results in input order, 1 per cycle, with the remaining 2 beats then accepted.
5. Streaming: out_ready=1, 16 consecutive random beats -> 16 results in order, 1 per cycle after 3-cycle latency, each matching a - b - bin against a scoreboard.
6. Reset mid-flight: 2 beats in the pipeline, assert rst for 1 cycle -> next cycle out_valid=0, in_ready=1, and no stale result ever appears.
